// File: rtl/asip_ctrl_pkg.sv
// Shared control types for the vector ASIP issue stage: scheduler state, register index layout.
package asip_ctrl_pkg;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } sched_state_e;

   localparam int REG_IDX_W  = 3;
   localparam int SCALAR_BIT = 2;

   function automatic logic is_scalar_reg(input logic [REG_IDX_W-1:0] idx);
      return idx[SCALAR_BIT];
   endfunction

endpackage

// File: rtl/issue_hazard_scheduler_sb_counter.sv
// Pending-write counter for one register: saturating up on issue, floored down on writeback.
module sb_counter #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             is_max
);

   logic dec_eff;

   assign is_max  = (cnt == {CNT_W{1'b1}});
   // A writeback against an idle register is dropped so an issue in the same cycle still counts.
   assign dec_eff = dec & (cnt != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (inc && !dec_eff && !is_max) begin
         cnt <= cnt + 1'b1;
      end else if (dec_eff && !inc) begin
         cnt <= cnt - 1'b1;
      end
   end

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (rst_n && dec && (cnt == '0))
         $warning("sb_counter: writeback to idle register ignored");
   end
`endif

endmodule

// File: rtl/issue_hazard_scheduler.sv
// Decode-to-execute issue control: RAW/WAW scoreboard stall and jump flush sequencing.
// Optional HAZARD_WB_BYPASS_EN: same-cycle writeback clears the hazard it resolves.
module issue_hazard_scheduler
   import asip_ctrl_pkg::*;
#(
   parameter int NREG         = 8,
   parameter int CNT_W        = 2,
   parameter int JUMP_PENALTY = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 dec_valid,
   input  logic [REG_IDX_W-1:0] dec_rs_a,
   input  logic                 dec_rs_a_used,
   input  logic [REG_IDX_W-1:0] dec_rs_b,
   input  logic                 dec_rs_b_used,
   input  logic [REG_IDX_W-1:0] dec_rd,
   input  logic                 dec_wr_en,
   input  logic                 dec_jump,
   input  logic                 wb_valid,
   input  logic [REG_IDX_W-1:0] wb_rd,
   output logic                 issue_valid,
   output logic                 stall,
   output logic                 flush,
   output logic [NREG-1:0]      busy_mask
);

   localparam int PEN_W = 3;

   logic [CNT_W-1:0] cnt [NREG];
   logic [NREG-1:0]  inc, dec, is_max, src_busy, wr_full;
   logic             hazard;
   logic             issue_int, stall_int, flush_int;

   sched_state_e     state_q, state_d;
   logic [PEN_W-1:0] pen_q, pen_d;

   for (genvar i = 0; i < NREG; i++) begin : g_sb
      assign inc[i]       = issue_int & dec_wr_en & (dec_rd == REG_IDX_W'(i));
      assign dec[i]       = wb_valid & (wb_rd == REG_IDX_W'(i));
      assign busy_mask[i] = (cnt[i] != '0);

`ifdef HAZARD_WB_BYPASS_EN
      // Last outstanding write retiring now is forwarded, so it no longer blocks readers.
      assign src_busy[i] = busy_mask[i] & ~(dec[i] & (cnt[i] == CNT_W'(1)));
      assign wr_full[i]  = is_max[i] & ~dec[i];
`else
      assign src_busy[i] = busy_mask[i];
      assign wr_full[i]  = is_max[i];
`endif

      sb_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk    (clk),
         .rst_n  (rst_n),
         .inc    (inc[i]),
         .dec    (dec[i]),
         .cnt    (cnt[i]),
         .is_max (is_max[i])
      );
   end

   assign hazard = (dec_rs_a_used & src_busy[dec_rs_a])
                 | (dec_rs_b_used & src_busy[dec_rs_b])
                 | (dec_wr_en     & wr_full[dec_rd]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         pen_q   <= '0;
      end else begin
         state_q <= state_d;
         pen_q   <= pen_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pen_d     = pen_q;
      issue_int = 1'b0;
      stall_int = 1'b0;
      flush_int = 1'b0;
      case (state_q)
         RUN: begin
            if (dec_valid) begin
               if (hazard) begin
                  stall_int = 1'b1;
               end else begin
                  issue_int = 1'b1;
                  if (dec_jump) begin
                     state_d = FLUSH;
                     pen_d   = PEN_W'(JUMP_PENALTY - 1);
                  end
               end
            end
         end
         FLUSH: begin
            flush_int = 1'b1;
            if (pen_q == '0) state_d = RUN;
            else             pen_d   = pen_q - 1'b1;
         end
         default: state_d = RUN;
      endcase
   end

   // Outputs forced low while reset is asserted, independent of decode inputs.
   assign issue_valid = rst_n & issue_int;
   assign stall       = rst_n & stall_int;
   assign flush       = rst_n & flush_int;

endmodule

// File: tb/tb_issue_hazard_scheduler.sv
// Directed self-checking bench for issue_hazard_scheduler (default parameters).
module tb_issue_hazard_scheduler;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       dec_valid, dec_rs_a_used, dec_rs_b_used, dec_wr_en, dec_jump, wb_valid;
   logic [2:0] dec_rs_a, dec_rs_b, dec_rd, wb_rd;
   logic       issue_valid, stall, flush;
   logic [7:0] busy_mask;

   int n_checks = 0;
   int n_errors = 0;

   issue_hazard_scheduler #(.NREG(8), .CNT_W(2), .JUMP_PENALTY(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .dec_valid(dec_valid),
      .dec_rs_a(dec_rs_a), .dec_rs_a_used(dec_rs_a_used),
      .dec_rs_b(dec_rs_b), .dec_rs_b_used(dec_rs_b_used),
      .dec_rd(dec_rd), .dec_wr_en(dec_wr_en), .dec_jump(dec_jump),
      .wb_valid(wb_valid), .wb_rd(wb_rd),
      .issue_valid(issue_valid), .stall(stall), .flush(flush),
      .busy_mask(busy_mask)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic iv, input logic st, input logic fl);
      chk({tag, ".issue"}, {7'd0, issue_valid}, {7'd0, iv});
      chk({tag, ".stall"}, {7'd0, stall},       {7'd0, st});
      chk({tag, ".flush"}, {7'd0, flush},       {7'd0, fl});
   endtask

   task automatic clr();
      dec_valid = 0; dec_rs_a = 0; dec_rs_a_used = 0; dec_rs_b = 0; dec_rs_b_used = 0;
      dec_rd = 0; dec_wr_en = 0; dec_jump = 0; wb_valid = 0; wb_rd = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_wr(input logic [2:0] rd);
      clr(); dec_valid = 1; dec_wr_en = 1; dec_rd = rd;
   endtask

   initial begin
      clr();
      rst_n = 0;
      #12;
      chk_out("reset", 0, 0, 0);
      chk("reset.busy", busy_mask, 8'h00);
      #6 rst_n = 1;
      tick();

      // RAW on r5
      issue_wr(3'd5); #1;
      chk_out("raw.issue_wr", 1, 0, 0);
      tick();
      clr(); dec_valid = 1; dec_rs_a = 5; dec_rs_a_used = 1; #1;
      chk("raw.busy", busy_mask, 8'h20);
      chk_out("raw.stall1", 0, 1, 0);
      tick(); #1;
      chk_out("raw.stall2", 0, 1, 0);
      wb_valid = 1; wb_rd = 5; #1;
`ifdef HAZARD_WB_BYPASS_EN
      chk_out("raw.wb_cycle", 1, 0, 0);
      tick();
      clr(); #1;
      chk("raw.busy_after", busy_mask, 8'h00);
`else
      chk_out("raw.wb_cycle", 0, 1, 0);
      tick();
      wb_valid = 0; #1;
      chk_out("raw.after_wb", 1, 0, 0);
      chk("raw.busy_after", busy_mask, 8'h00);
`endif
      tick();

      // WAW saturation on r2
      for (int k = 0; k < 3; k++) begin
         issue_wr(3'd2); #1;
         chk_out("sat.writer", 1, 0, 0);
         tick();
      end
      issue_wr(3'd2); #1;
      chk("sat.busy", busy_mask, 8'h04);
      chk_out("sat.fourth", 0, 1, 0);
      clr(); wb_valid = 1; wb_rd = 2;
      tick(); tick(); #1;
      chk("sat.busy_mid", busy_mask, 8'h04);
      tick();
      clr(); #1;
      chk("sat.drained", busy_mask, 8'h00);

      // Issue and writeback of r3 in the same cycle
      issue_wr(3'd3); #1;
      tick();
      issue_wr(3'd3); wb_valid = 1; wb_rd = 3; #1;
      chk_out("same.issue", 1, 0, 0);
      tick();
      clr(); #1;
      chk("same.busy", busy_mask, 8'h08);
      wb_valid = 1; wb_rd = 3;
      tick();
      clr(); #1;
      chk("same.cleared", busy_mask, 8'h00);

      // Jump flush window
      clr(); dec_valid = 1; dec_jump = 1; #1;
      chk_out("jump.issue", 1, 0, 0);
      tick();
      clr(); dec_valid = 1; #1;
      chk_out("jump.flush1", 0, 0, 1);
      tick(); #1;
      chk_out("jump.flush2", 0, 0, 1);
      tick(); #1;
      chk_out("jump.run", 1, 0, 0);
      tick();

      // Writeback to idle r6 must not wrap the counter
      clr(); wb_valid = 1; wb_rd = 6; #1;
      chk_out("idle.wb", 0, 0, 0);
      tick();
      issue_wr(3'd6); #1;
      chk("idle.busy", busy_mask, 8'h00);
      chk_out("idle.reissue", 1, 0, 0);
      tick();
      clr(); #1;
      chk("idle.busy_after", busy_mask, 8'h40);
      wb_valid = 1; wb_rd = 6;
      tick();

      // Reset in the middle of a flush with two writers pending on r1
      issue_wr(3'd1); tick();
      issue_wr(3'd1); tick();
      clr(); dec_valid = 1; dec_jump = 1; #1;
      chk("rst.busy_pre", busy_mask, 8'h02);
      tick();
      clr(); #1;
      chk_out("rst.in_flush", 0, 0, 1);
      dec_valid = 1;
      rst_n = 0; #1;
      chk_out("rst.async", 0, 0, 0);
      chk("rst.busy", busy_mask, 8'h00);
      #3 rst_n = 1;
      tick();
      clr(); dec_valid = 1; dec_rs_a = 1; dec_rs_a_used = 1; #1;
      chk_out("rst.run", 1, 0, 0);
      tick();
      clr();
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #20000;
      n_errors++;
      $display("FAIL timeout observed=running required=finished");
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $fatal(1, "timeout");
   end

endmodule
